multi_cam_wr_arbiter: RTL and testbench

- N-channel successor to the fixed dual-camera write path. Merges N camera line streams into one DDR3 write-command/data port.
- Each channel is assigned a side-by-side horizontal slice of a shared frame, so the frame is stored left-to-right per channel.
- Supports round-robin burst arbitration, per-channel ping-pong frame banks and per-channel frame-complete tracking.
- Sits between the per-camera CDC FIFOs and the DDR3 controller user port, all in the DDR user clock domain.

---
 rtl/multi_cam_wr_arbiter_if.sv | 32 +++
 rtl/multi_cam_wr_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_multi_cam_wr_arbiter.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_cam_wr_arbiter_if.sv
// Camera-FIFO side and DDR3 user-port side signals of the multi-camera write arbiter.
// The arbiter uses the master modport; the FIFOs and DDR controller sit on the slave side.
interface multi_cam_wr_arbiter_if #(
    parameter int unsigned CH_NUM = 2,
    parameter int unsigned DW     = 16,
    parameter int unsigned AW     = 28
);
    logic [CH_NUM-1:0]    ch_frame_start;
    logic [CH_NUM-1:0]    ch_burst_rdy;
    logic [CH_NUM*DW-1:0] ch_fifo_data;
    logic [CH_NUM-1:0]    ch_fifo_rd;
    logic                 wr_cmd_valid;
    logic                 wr_cmd_ready;
    logic [AW-1:0]        wr_cmd_addr;
    logic [7:0]           wr_cmd_len;
    logic                 wr_data_req;
    logic [DW-1:0]        wr_data;
    logic [CH_NUM-1:0]    ch_rd_bank;
    logic [CH_NUM-1:0]    ch_frame_done;

    modport master (
        input  ch_frame_start, ch_burst_rdy, ch_fifo_data, wr_cmd_ready, wr_data_req,
        output ch_fifo_rd, wr_cmd_valid, wr_cmd_addr, wr_cmd_len, wr_data, ch_rd_bank,
               ch_frame_done
    );

    modport slave (
        output ch_frame_start, ch_burst_rdy, ch_fifo_data, wr_cmd_ready, wr_data_req,
        input  ch_fifo_rd, wr_cmd_valid, wr_cmd_addr, wr_cmd_len, wr_data, ch_rd_bank,
               ch_frame_done
    );
endinterface

// File: rtl/multi_cam_wr_arbiter.sv
// Round-robin merge of CH_NUM camera line streams into one DDR3 burst write port.
// Define MCW_PINGPONG_EN for per-channel ping-pong frame banks; otherwise bank 0 only.
module multi_cam_wr_arbiter #(
    parameter int unsigned CH_NUM    = 2,
    parameter int unsigned DW        = 16,
    parameter int unsigned AW        = 28,
    parameter int unsigned H_SUB     = 640,
    parameter int unsigned V_LINES   = 720,
    parameter int unsigned BURST_LEN = 80
) (
    input  logic                   clk,
    input  logic                   rst_n,
    multi_cam_wr_arbiter_if.master bus
);
    localparam int unsigned LINE_STRIDE = CH_NUM * H_SUB;
    localparam int unsigned FRAME_WORDS = LINE_STRIDE * V_LINES;
    localparam int unsigned BPL         = H_SUB / BURST_LEN;
    localparam int unsigned IW          = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam int unsigned LW          = (V_LINES > 1) ? $clog2(V_LINES) : 1;
    localparam int unsigned BW          = (BPL > 1) ? $clog2(BPL) : 1;

    typedef enum logic [1:0] {StIdle, StCmd, StData, StUpd} state_e;

    state_e            state_q, state_d;
    logic [IW-1:0]     grant_q, grant_d, rr_q, rr_d;
    logic [7:0]        beat_q, beat_d, len_q, len_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic [CH_NUM-1:0] pend_q, pend_d, fdone_q, fdone_d, wbank_q, wbank_d;
    logic [CH_NUM-1:0] rd_bank_q, rd_bank_d, frame_done_q, frame_done_d;
    logic [LW-1:0]     line_q [CH_NUM];
    logic [LW-1:0]     line_d [CH_NUM];
    logic [BW-1:0]     bcnt_q [CH_NUM];
    logic [BW-1:0]     bcnt_d [CH_NUM];
    logic [CH_NUM-1:0] elig;
    logic              found;
    logic [IW-1:0]     sel, idx;

    function automatic logic [AW-1:0] burst_addr(input logic bank, input logic [LW-1:0] line,
                                                 input logic [IW-1:0] ch, input logic [BW-1:0] bc);
        return AW'(bank) * AW'(FRAME_WORDS) + AW'(line) * AW'(LINE_STRIDE) +
               AW'(ch) * AW'(H_SUB) + AW'(bc) * AW'(BURST_LEN);
    endfunction

    // First eligible channel at or after the round-robin pointer, wrapping.
    always_comb begin
        elig  = bus.ch_burst_rdy & ~pend_q;
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int unsigned k = 0; k < CH_NUM; k++) begin
            idx = IW'((32'(rr_q) + k) % CH_NUM);
            if (!found && elig[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        rr_d         = rr_q;
        beat_d       = beat_q;
        len_d        = len_q;
        addr_d       = addr_q;
        pend_d       = pend_q | bus.ch_frame_start;
        fdone_d      = fdone_q;
        wbank_d      = wbank_q;
        rd_bank_d    = rd_bank_q;
        frame_done_d = '0;
        line_d       = line_q;
        bcnt_d       = bcnt_q;

        // Pending frame starts land in IDLE, or in UPD for channels other than the one updating.
        for (int unsigned i = 0; i < CH_NUM; i++) begin
            if (pend_q[i] && ((state_q == StIdle) ||
                              ((state_q == StUpd) && (i != 32'(grant_q))))) begin
                line_d[i]  = '0;
                bcnt_d[i]  = '0;
                fdone_d[i] = 1'b0;
                pend_d[i]  = bus.ch_frame_start[i];
            end
        end

        case (state_q)
            StIdle: begin
                if (found) begin
                    grant_d = sel;
                    addr_d  = burst_addr(wbank_q[sel], line_q[sel], sel, bcnt_q[sel]);
                    len_d   = 8'(BURST_LEN);
                    beat_d  = '0;
                    state_d = StCmd;
                end
            end
            StCmd: begin
                if (bus.wr_cmd_ready) state_d = StData;
            end
            StData: begin
                if (bus.wr_data_req) begin
                    beat_d = beat_q + 8'd1;
                    if (beat_q == 8'(BURST_LEN - 1)) state_d = StUpd;
                end
            end
            StUpd: begin
                state_d = StIdle;
                rr_d    = (32'(grant_q) == CH_NUM - 1) ? '0 : grant_q + 1'b1;
                if (bcnt_q[grant_q] == BW'(BPL - 1)) begin
                    bcnt_d[grant_q] = '0;
                    if (line_q[grant_q] == LW'(V_LINES - 1)) begin
                        line_d[grant_q]       = '0;
                        frame_done_d[grant_q] = 1'b1;
                        fdone_d[grant_q]      = 1'b1;
`ifdef MCW_PINGPONG_EN
                        rd_bank_d[grant_q] = wbank_q[grant_q];
                        wbank_d[grant_q]   = ~wbank_q[grant_q];
`endif
                    end else begin
                        line_d[grant_q] = line_q[grant_q] + 1'b1;
                    end
                end else begin
                    bcnt_d[grant_q] = bcnt_q[grant_q] + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        cmd_valid_d = (state_d == StCmd);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            rr_q         <= '0;
            beat_q       <= '0;
            len_q        <= '0;
            addr_q       <= '0;
            cmd_valid_q  <= 1'b0;
            pend_q       <= '0;
            fdone_q      <= '0;
            wbank_q      <= '0;
            rd_bank_q    <= '0;
            frame_done_q <= '0;
            for (int unsigned i = 0; i < CH_NUM; i++) begin
                line_q[i] <= '0;
                bcnt_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            rr_q         <= rr_d;
            beat_q       <= beat_d;
            len_q        <= len_d;
            addr_q       <= addr_d;
            cmd_valid_q  <= cmd_valid_d;
            pend_q       <= pend_d;
            fdone_q      <= fdone_d;
            wbank_q      <= wbank_d;
            rd_bank_q    <= rd_bank_d;
            frame_done_q <= frame_done_d;
            line_q       <= line_d;
            bcnt_q       <= bcnt_d;
        end
    end

    always_comb begin
        bus.ch_fifo_rd = '0;
        bus.wr_data    = '0;
        if (state_q == StData) begin
            bus.ch_fifo_rd[grant_q] = bus.wr_data_req;
            for (int unsigned i = 0; i < CH_NUM; i++) begin
                if (IW'(i) == grant_q) bus.wr_data = bus.ch_fifo_data[i*DW +: DW];
            end
        end
    end

    assign bus.wr_cmd_valid  = cmd_valid_q;
    assign bus.wr_cmd_addr   = addr_q;
    assign bus.wr_cmd_len    = len_q;
    assign bus.ch_rd_bank    = rd_bank_q;
    assign bus.ch_frame_done = frame_done_q;
endmodule

// File: tb/tb_multi_cam_wr_arbiter.sv
// Randomized bench for multi_cam_wr_arbiter against a transaction-level frame/address model.
`timescale 1ns/1ps
module tb_multi_cam_wr_arbiter;
    localparam int unsigned CH     = 2;
    localparam int unsigned DW     = 16;
    localparam int unsigned AW     = 28;
    localparam int unsigned HS     = 16;
    localparam int unsigned VL     = 4;
    localparam int unsigned BL     = 8;
    localparam int unsigned BPL    = HS / BL;
    localparam int unsigned STRIDE = CH * HS;
    localparam int unsigned FRAME  = STRIDE * VL;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multi_cam_wr_arbiter_if #(.CH_NUM(CH), .DW(DW), .AW(AW)) bus ();

    multi_cam_wr_arbiter #(
        .CH_NUM(CH), .DW(DW), .AW(AW), .H_SUB(HS), .V_LINES(VL), .BURST_LEN(BL)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Fake FIFOs: each channel presents {channel, word count} and advances on pop.
    int wcnt [CH];
    always_comb begin
        bus.ch_fifo_data = '0;
        for (int i = 0; i < CH; i++) bus.ch_fifo_data[i*DW +: DW] = DW'(i * 4096 + wcnt[i] % 4096);
    end

    int            m_line [CH];
    int            m_bcnt [CH];
    int            m_wbank [CH];
    logic [CH-1:0] m_rdbank;
    int            m_rr;
    logic [CH-1:0] exp_done;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < CH; i++) begin
            m_line[i]  = 0;
            m_bcnt[i]  = 0;
            m_wbank[i] = 0;
        end
        m_rdbank = '0;
        m_rr     = 0;
        exp_done = '0;
    endfunction

    function automatic int m_pick(input logic [CH-1:0] rdy);
        for (int k = 0; k < CH; k++) begin
            if (rdy[(m_rr + k) % CH]) return (m_rr + k) % CH;
        end
        return 0;
    endfunction

    function automatic logic [AW-1:0] m_addr(input int c);
        return AW'(m_wbank[c] * FRAME + m_line[c] * STRIDE + c * HS + m_bcnt[c] * BL);
    endfunction

    function automatic logic [DW-1:0] exp_word(input int c);
        return DW'(c * 4096 + wcnt[c] % 4096);
    endfunction

    function automatic void model_update(input int g, input bit started, input int sx);
        exp_done = '0;
        m_bcnt[g]++;
        if (m_bcnt[g] == BPL) begin
            m_bcnt[g] = 0;
            m_line[g]++;
            if (m_line[g] == VL) begin
                m_line[g]   = 0;
                exp_done[g] = 1'b1;
`ifdef MCW_PINGPONG_EN
                m_rdbank[g] = m_wbank[g][0];
                m_wbank[g]  = 1 - m_wbank[g];
`endif
            end
        end
        // A restart only rewinds the line position; the bank is left alone.
        if (started) begin
            m_line[sx] = 0;
            m_bcnt[sx] = 0;
        end
        m_rr = (g + 1) % CH;
    endfunction

    // Idle/arbitration window: no pops allowed, collect frame-done pulses, optionally await a command.
    task automatic watch(input int max_cyc, input bit need_valid);
        bit            got = 1'b0;
        int            stray = 0;
        int            done_cyc = 0;
        logic [CH-1:0] done_acc = '0;
        for (int c = 0; c < max_cyc && !got; c++) begin
            @(negedge clk);
            bus.wr_data_req = 1'($urandom_range(0, 1));
            #1;
            if (bus.ch_fifo_rd != '0) stray++;
            if (bus.ch_frame_done != '0) begin
                done_acc |= bus.ch_frame_done;
                done_cyc++;
            end
            if (bus.wr_cmd_valid) got = 1'b1;
        end
        check_eq("stray_pop", 64'(stray), 64'd0);
        check_eq("frame_done", 64'(done_acc), 64'(exp_done));
        check_eq("frame_done_width", 64'(done_cyc), (exp_done != '0) ? 64'd1 : 64'd0);
        check_eq("rd_bank", 64'(bus.ch_rd_bank), 64'(m_rdbank));
        check_eq(need_valid ? "cmd_timeout" : "idle_cmd_valid", 64'(got), 64'(need_valid));
        exp_done = '0;
    endtask

    task automatic do_burst(input logic [CH-1:0] rdy, input int stall_n, input bit allow_start);
        int g;
        int beats = 0;
        int guard = 0;
        int sx;
        int sbeat;
        bit started = 1'b0;
        bus.ch_burst_rdy = rdy;
        g = m_pick(rdy);
        watch(200, 1'b1);
        check_eq("cmd_addr", 64'(bus.wr_cmd_addr), 64'(m_addr(g)));
        check_eq("cmd_len", 64'(bus.wr_cmd_len), 64'(BL));
        for (int s = 0; s < stall_n; s++) begin
            @(negedge clk);
            bus.wr_data_req = 1'($urandom_range(0, 1));
            #1;
            check_eq("stall_valid", 64'(bus.wr_cmd_valid), 64'd1);
            check_eq("stall_addr", 64'(bus.wr_cmd_addr), 64'(m_addr(g)));
            check_eq("stall_pop", 64'(bus.ch_fifo_rd), 64'd0);
        end
        bus.wr_cmd_ready = 1'b1;
        @(negedge clk);
        bus.wr_cmd_ready = 1'b0;
        sx    = $urandom_range(0, CH - 1);
        sbeat = allow_start ? $urandom_range(0, BL - 1) : BL;
        while (beats < BL && guard < 100) begin
            guard++;
            bus.wr_data_req = ($urandom_range(0, 3) != 0);
            if (!started && beats == sbeat) begin
                bus.ch_frame_start = CH'(1 << sx);
                started = 1'b1;
            end
            #1;
            check_eq("pop", 64'(bus.ch_fifo_rd), bus.wr_data_req ? 64'(1 << g) : 64'd0);
            if (bus.wr_data_req) check_eq("wr_data", 64'(bus.wr_data), 64'(exp_word(g)));
            @(posedge clk);
            #1;
            if (bus.wr_data_req) begin
                wcnt[g]++;
                beats++;
            end
            @(negedge clk);
            bus.ch_frame_start = '0;
        end
        bus.wr_data_req = 1'b1;
        #1;
        check_eq("overrun_pop", 64'(bus.ch_fifo_rd), 64'd0);
        bus.wr_data_req = 1'b0;
        model_update(g, started, sx);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        for (int i = 0; i < CH; i++) wcnt[i] = 0;
        bus.ch_frame_start = '0;
        bus.ch_burst_rdy   = '0;
        bus.wr_cmd_ready   = 1'b0;
        bus.wr_data_req    = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_cmd_valid", 64'(bus.wr_cmd_valid), 64'd0);
        check_eq("rst_cmd_addr", 64'(bus.wr_cmd_addr), 64'd0);
        check_eq("rst_cmd_len", 64'(bus.wr_cmd_len), 64'd0);
        check_eq("rst_pop", 64'(bus.ch_fifo_rd), 64'd0);
        check_eq("rst_wr_data", 64'(bus.wr_data), 64'd0);
        check_eq("rst_rd_bank", 64'(bus.ch_rd_bank), 64'd0);
        check_eq("rst_frame_done", 64'(bus.ch_frame_done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.wr_data_req = 1'b0;
        watch(4, 1'b0);

        // Single channel through a full frame and into the next.
        for (int n = 0; n < 10; n++) do_burst(2'b01, 0, 1'b0);
        // Both ready: strict alternation.
        for (int n = 0; n < 6; n++) do_burst(2'b11, 0, 1'b0);
        // Command acceptance withheld for 5 cycles.
        for (int n = 0; n < 2; n++) do_burst(2'b11, 5, 1'b0);
        // Random readiness, stalls and frame restarts.
        for (int n = 0; n < 60; n++)
            do_burst(CH'($urandom_range(1, (1 << CH) - 1)), $urandom_range(0, 3),
                     ($urandom_range(0, 2) == 0));

        // Reset in the middle of a data phase.
        bus.ch_burst_rdy = 2'b10;
        g = m_pick(2'b10);
        watch(200, 1'b1);
        check_eq("pre_rst_addr", 64'(bus.wr_cmd_addr), 64'(m_addr(g)));
        bus.wr_cmd_ready = 1'b1;
        @(negedge clk);
        bus.wr_cmd_ready = 1'b0;
        bus.wr_data_req  = 1'b1;
        for (int b = 0; b < 3; b++) begin
            @(posedge clk);
            #1;
            wcnt[g]++;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_cmd_valid", 64'(bus.wr_cmd_valid), 64'd0);
        check_eq("midrst_pop", 64'(bus.ch_fifo_rd), 64'd0);
        check_eq("midrst_rd_bank", 64'(bus.ch_rd_bank), 64'd0);
        @(negedge clk);
        bus.wr_data_req = 1'b0;
        rst_n = 1'b1;
        model_reset();
        for (int n = 0; n < 4; n++) do_burst(2'b11, 0, 1'b0);

        bus.ch_burst_rdy = '0;
        watch(6, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
